// File: rtl/lite_nasti_read_arbiter.sv
// lite_nasti_read_arbiter
//   Shares one NASTI-Lite read port (AR/R) among NUM_MASTER read masters.
//   The AR channel is arbitrated round-robin. The granted master's index is
//   prepended to its ID. R beats are routed back by the upper MW bits of s_r_id.
//   Each master has a credit limit of MAX_OUTSTANDING reads in flight.
//   The block has no buffering. Both channels are pure combinational paths.
// Ports
//   clk, rstn           : clock, async active-low reset (outputs held idle in reset)
//   m_ar_*              : per-master AR requests (packed [NUM_MASTER-1:0][..])
//   m_ar_ready          : per-master AR ready, only the granted master's bit can be set
//   m_r_*               : per-master R responses, payload broadcast, valid one-hot
//   s_ar_*              : shared AR port, s_ar_id = {grant index, master id}
//   s_r_*               : shared R port

// Per-master outstanding-read credit counter.
module lite_nasti_read_credit #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CW              = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_avail
);
    logic [CW-1:0] r_cnt;
    logic          w_dec_ok;

    // A stray R beat when nothing is outstanding is allowed through, but the count stays at 0.
    assign w_dec_ok = i_dec && (r_cnt != '0);
    assign o_avail  = int'(r_cnt) < MAX_OUTSTANDING;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else begin
            case ({i_inc, w_dec_ok})
                2'b10:   if (o_avail) r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;  // idle, or issue and retire in the same cycle
            endcase
        end
    end
endmodule

module lite_nasti_read_arbiter #(
    parameter int NUM_MASTER      = 2,
    parameter int ID_WIDTH        = 1,
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 32,
    parameter int USER_WIDTH      = 1,
    parameter int MAX_OUTSTANDING = 2,
    localparam int MW             = $clog2(NUM_MASTER),
    localparam int SID_WIDTH      = ID_WIDTH + MW
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic [NUM_MASTER-1:0][ID_WIDTH-1:0]    m_ar_id,
    input  logic [NUM_MASTER-1:0][ADDR_WIDTH-1:0]  m_ar_addr,
    input  logic [NUM_MASTER-1:0][2:0]             m_ar_prot,
    input  logic [NUM_MASTER-1:0][3:0]             m_ar_qos,
    input  logic [NUM_MASTER-1:0][3:0]             m_ar_region,
    input  logic [NUM_MASTER-1:0][USER_WIDTH-1:0]  m_ar_user,
    input  logic [NUM_MASTER-1:0]                  m_ar_valid,
    output logic [NUM_MASTER-1:0]                  m_ar_ready,
    output logic [NUM_MASTER-1:0][ID_WIDTH-1:0]    m_r_id,
    output logic [NUM_MASTER-1:0][DATA_WIDTH-1:0]  m_r_data,
    output logic [NUM_MASTER-1:0][1:0]             m_r_resp,
    output logic [NUM_MASTER-1:0][USER_WIDTH-1:0]  m_r_user,
    output logic [NUM_MASTER-1:0]                  m_r_valid,
    input  logic [NUM_MASTER-1:0]                  m_r_ready,
    output logic [SID_WIDTH-1:0]                   s_ar_id,
    output logic [ADDR_WIDTH-1:0]                  s_ar_addr,
    output logic [2:0]                             s_ar_prot,
    output logic [3:0]                             s_ar_qos,
    output logic [3:0]                             s_ar_region,
    output logic [USER_WIDTH-1:0]                  s_ar_user,
    output logic                                   s_ar_valid,
    input  logic                                   s_ar_ready,
    input  logic [SID_WIDTH-1:0]                   s_r_id,
    input  logic [DATA_WIDTH-1:0]                  s_r_data,
    input  logic [1:0]                             s_r_resp,
    input  logic [USER_WIDTH-1:0]                  s_r_user,
    input  logic                                   s_r_valid,
    output logic                                   s_r_ready
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;

    state_t                r_state, w_state_nxt;
    logic [MW-1:0]         r_rr_ptr, r_lock_idx;
    logic [MW-1:0]         w_arb_idx, w_cand, w_grant, w_r_idx;
    logic                  w_arb_any, w_s_ar_valid, w_ar_hs, w_s_r_ready;
    logic [NUM_MASTER-1:0] w_avail, w_elig, w_inc, w_dec;

    // Credit counters, one per master.
    lite_nasti_read_credit #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING),
        .CW             (CW)
    ) u_credit [NUM_MASTER-1:0] (
        .clk    (clk),
        .rstn   (rstn),
        .i_inc  (w_inc),
        .i_dec  (w_dec),
        .o_avail(w_avail)
    );

    assign w_elig = m_ar_valid & w_avail;

    // Round-robin search from r_rr_ptr. The loop runs downwards so the
    // nearest eligible index (smallest offset) is written last and wins.
    always_comb begin
        w_arb_idx = '0;
        w_arb_any = 1'b0;
        w_cand    = '0;
        for (int k = NUM_MASTER - 1; k >= 0; k--) begin
            w_cand = MW'((int'(r_rr_ptr) + k) % NUM_MASTER);
            if (w_elig[w_cand]) begin
                w_arb_idx = w_cand;
                w_arb_any = 1'b1;
            end
        end
    end

    // LOCK pins the grant while a presented AR waits for ready, so the AR
    // payload stays stable even if the round-robin choice would change.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant      = w_arb_idx;
        w_s_ar_valid = w_arb_any;
        if (r_state == LOCK) begin
            w_grant      = r_lock_idx;
            w_s_ar_valid = m_ar_valid[r_lock_idx];
        end
        if (!rstn) w_s_ar_valid = 1'b0;
        w_ar_hs = w_s_ar_valid && s_ar_ready;
        case (r_state)
            ARB:     if (w_s_ar_valid && !s_ar_ready) w_state_nxt = LOCK;
            LOCK:    if (w_ar_hs) w_state_nxt = ARB;
            default: w_state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ARB;
            r_rr_ptr   <= '0;
            r_lock_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ARB && w_s_ar_valid && !s_ar_ready) r_lock_idx <= w_grant;
            if (w_ar_hs)
                r_rr_ptr <= (int'(w_grant) + 1 == NUM_MASTER) ? '0 : w_grant + MW'(1);
        end
    end

    // AR mux
    assign s_ar_valid  = w_s_ar_valid;
    assign s_ar_id     = {w_grant, m_ar_id[w_grant]};
    assign s_ar_addr   = m_ar_addr[w_grant];
    assign s_ar_prot   = m_ar_prot[w_grant];
    assign s_ar_qos    = m_ar_qos[w_grant];
    assign s_ar_region = m_ar_region[w_grant];
    assign s_ar_user   = m_ar_user[w_grant];

    // R routing. An index with no master behind it (when NUM_MASTER is not
    // a power of 2) keeps the default ready=1, so the beat is dropped.
    assign w_r_idx = s_r_id[SID_WIDTH-1 -: MW];

    always_comb begin
        w_s_r_ready = 1'b1;
        for (int i = 0; i < NUM_MASTER; i++)
            if (w_r_idx == MW'(i)) w_s_r_ready = m_r_ready[i];
        if (!rstn) w_s_r_ready = 1'b0;
    end

    assign s_r_ready = w_s_r_ready;

    for (genvar i = 0; i < NUM_MASTER; i++) begin : g_master
        assign m_ar_ready[i] = w_ar_hs && (w_grant == MW'(i));
        assign m_r_valid[i]  = rstn && s_r_valid && (w_r_idx == MW'(i));
        assign m_r_id[i]     = s_r_id[ID_WIDTH-1:0];
        assign m_r_data[i]   = s_r_data;
        assign m_r_resp[i]   = s_r_resp;
        assign m_r_user[i]   = s_r_user;
        assign w_inc[i]      = m_ar_ready[i];
        assign w_dec[i]      = m_r_valid[i] && m_r_ready[i];
    end
endmodule
